// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// Request fields stay stable while dmem_req is high; read data is valid with dmem_ack.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes width and sign, checks alignment and legality, issues one
// data-memory access with byte lanes, and returns the aligned, extended load result.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  error,
  load_store_unit_if.master dmem
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [1:0] ErrOk        = 2'b00;
  localparam logic [1:0] ErrMisalign  = 2'b01;
  localparam logic [1:0] ErrIllegal   = 2'b10;
  localparam logic [1:0] ErrTimeout   = 2'b11;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_q, load_d;
  logic [1:0]        err_q, err_d;

  // Request decode, evaluated on the live inputs in the accepting cycle
  logic        illegal, misaligned;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;

  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_read) begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else if (mem_write) begin
      illegal = funct3[2] || (funct3[1:0] == 2'b11);
    end

    misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));

    be_dec    = 4'b1111;
    wdata_dec = store_data;
    unique case (funct3[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << alu_result[1:0];
        wdata_dec = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_dec    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {2{store_data[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_dec = store_data;
      end
    endcase
  end

  // Load extraction from the returned word, using the registered width and offset
  logic [31:0] lane, extracted;

  always_comb begin
    lane      = dmem.dmem_rdata >> {off_q, 3'b000};
    extracted = lane;
    unique case (f3_q)
      3'b000:  extracted = {{24{lane[7]}}, lane[7:0]};
      3'b100:  extracted = {24'h0, lane[7:0]};
      3'b001:  extracted = {{16{lane[15]}}, lane[15:0]};
      3'b101:  extracted = {16'h0, lane[15:0]};
      default: extracted = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    // Result outputs are only non-zero during the single DONE cycle
    load_d  = 32'h0;
    err_d   = ErrOk;

    unique case (state_q)
      StIdle: begin
        if (start && (mem_read || mem_write)) begin
          if (illegal || misaligned) begin
            state_d = StDone;
            err_d   = illegal ? ErrIllegal : ErrMisalign;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
            f3_d    = funct3;
            off_d   = alu_result[1:0];
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = be_dec;
            wdata_d = mem_write ? wdata_dec : 32'h0;
          end
        end
      end
      StReq: begin
        if (dmem.dmem_ack || (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
          state_d = StDone;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0;
          be_d    = 4'h0;
          wdata_d = 32'h0;
          if (dmem.dmem_ack) begin
            load_d = we_q ? 32'h0 : extracted;
          end else begin
            err_d  = ErrTimeout;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      load_q  <= 32'h0;
      err_q   <= ErrOk;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign load_data       = load_q;
  assign error           = err_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout, ignored starts, reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  error;

  int total = 0;
  int bad   = 0;

  load_store_unit_if bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .error      (error),
    .dmem       (bus.master)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    start      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = addr;
    store_data = sd;
    tick();
    // Scramble inputs so a design that fails to register them is caught
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b111;
    alu_result = 32'hFFFF_FFFF;
    store_data = 32'h5555_5555;
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    funct3         = 3'b000;
    alu_result     = 32'h0;
    store_data     = 32'h0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_req", {31'h0, bus.dmem_req}, 32'h0);
    check("rst_err", {30'h0, error}, 32'h0);
    check("rst_ld", load_data, 32'h0);
    check("rst_be", {28'h0, bus.dmem_be}, 32'h0);

    // LB at 0x103, two wait cycles
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check("lb_req", {31'h0, bus.dmem_req}, 32'h1);
    check("lb_we", {31'h0, bus.dmem_we}, 32'h0);
    check("lb_addr", bus.dmem_addr, 32'h0000_0100);
    check("lb_be", {28'h0, bus.dmem_be}, 32'h8);
    check("lb_busy", {31'h0, busy}, 32'h1);
    tick();
    check("lb_wait1", {31'h0, bus.dmem_req}, 32'h1);
    tick();
    check("lb_wait2", {31'h0, bus.dmem_req}, 32'h1);
    check("lb_nodone", {31'h0, done}, 32'h0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h80FF_1234;
    tick();
    bus.dmem_ack   = 1'b0;
    check("lb_done", {31'h0, done}, 32'h1);
    check("lb_data", load_data, 32'hFFFF_FF80);
    check("lb_err", {30'h0, error}, 32'h0);
    check("lb_req_drop", {31'h0, bus.dmem_req}, 32'h0);
    tick();
    check("lb_done_pulse", {31'h0, done}, 32'h0);
    check("lb_idle", {31'h0, busy}, 32'h0);
    check("lb_ld_clr", load_data, 32'h0);

    // SH at 0x202, zero-wait ack
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
    bus.dmem_ack = 1'b1;
    check("sh_we", {31'h0, bus.dmem_we}, 32'h1);
    check("sh_addr", bus.dmem_addr, 32'h0000_0200);
    check("sh_be", {28'h0, bus.dmem_be}, 32'hC);
    check("sh_wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
    tick();
    bus.dmem_ack = 1'b0;
    check("sh_done", {31'h0, done}, 32'h1);
    check("sh_err", {30'h0, error}, 32'h0);
    check("sh_ld", load_data, 32'h0);
    tick();

    // LW misaligned at 0x6
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    check("lw_mis_done", {31'h0, done}, 32'h1);
    check("lw_mis_err", {30'h0, error}, 32'h1);
    check("lw_mis_req", {31'h0, bus.dmem_req}, 32'h0);
    tick();
    check("lw_mis_end", {31'h0, done}, 32'h0);

    // LHU at 0x6
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0);
    check("lhu_be", {28'h0, bus.dmem_be}, 32'hC);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hABCD_0000;
    tick();
    bus.dmem_ack   = 1'b0;
    check("lhu_data", load_data, 32'h0000_ABCD);
    tick();

    // LBU at 0x1
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0);
    check("lbu_be", {28'h0, bus.dmem_be}, 32'h2);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h0000_F500;
    tick();
    bus.dmem_ack   = 1'b0;
    check("lbu_data", load_data, 32'h0000_00F5);
    tick();

    // Illegal: read and write together
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0);
    check("ill_rw_err", {30'h0, error}, 32'h2);
    check("ill_rw_req", {31'h0, bus.dmem_req}, 32'h0);
    tick();

    // Illegal store width at an odd address: illegal wins over misaligned
    issue(1'b0, 1'b1, 3'b101, 32'h0000_0041, 32'h0);
    check("ill_prio_err", {30'h0, error}, 32'h2);
    tick();

    // Illegal load funct3 011
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0);
    check("ill_ld_err", {30'h0, error}, 32'h2);
    tick();

    // SB at 0x1
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678);
    check("sb_be", {28'h0, bus.dmem_be}, 32'h2);
    check("sb_wdata", bus.dmem_wdata, 32'h7878_7878);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    check("sb_done", {31'h0, done}, 32'h1);
    tick();

    // Start with neither read nor write, and a stray ack in IDLE: both ignored
    bus.dmem_ack = 1'b1;
    issue(1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    bus.dmem_ack = 1'b0;
    check("nop_busy", {31'h0, busy}, 32'h0);
    check("nop_done", {31'h0, done}, 32'h0);

    // Timeout: 16 request cycles, second start while busy ignored
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_req%0d", i), {31'h0, bus.dmem_req}, 32'h1);
      check($sformatf("to_addr%0d", i), bus.dmem_addr, 32'h0000_0010);
      check($sformatf("to_nodone%0d", i), {31'h0, done}, 32'h0);
      if (i == 3) begin
        start     = 1'b1;
        mem_read  = 1'b1;
        funct3    = 3'b010;
        alu_result = 32'h0000_0080;
      end else begin
        start     = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("to_done", {31'h0, done}, 32'h1);
    check("to_err", {30'h0, error}, 32'h3);
    check("to_req_drop", {31'h0, bus.dmem_req}, 32'h0);
    tick();
    check("to_idle", {31'h0, busy}, 32'h0);

    // Ack on the last allowed cycle beats the timeout
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check("late_req", {31'h0, bus.dmem_req}, 32'h1);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h8001_0000;
    tick();
    bus.dmem_ack   = 1'b0;
    check("late_err", {30'h0, error}, 32'h0);
    check("late_data", load_data, 32'hFFFF_8001);
    tick();

    // Reset during REQ
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
    check("rr_req", {31'h0, bus.dmem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_req0", {31'h0, bus.dmem_req}, 32'h0);
    check("rr_busy0", {31'h0, busy}, 32'h0);
    check("rr_done0", {31'h0, done}, 32'h0);
    tick();
    check("rr_nodone", {31'h0, done}, 32'h0);

    // SW after reset proceeds normally
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0024, 32'hCAFE_F00D);
    check("sw_addr", bus.dmem_addr, 32'h0000_0024);
    check("sw_be", {28'h0, bus.dmem_be}, 32'hF);
    check("sw_wdata", bus.dmem_wdata, 32'hCAFE_F00D);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    check("sw_done", {31'h0, done}, 32'h1);
    check("sw_err", {30'h0, error}, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
